load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit:
// funct3 codes, FSM state encoding and the data-window limit.
package lsu_pkg;

    // Memory address width; the data window is half the address space.
    localparam int unsigned LSU_ADDR_W = 9;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } lsu_state_e;

    // First byte address outside the data window.
    function automatic logic [31:0] win_limit(input int unsigned addr_w);
        return 32'd1 << (addr_w - 1);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports: funct3_i/off_i select width and lane, word_i is the memory
// word, sdata_i the store data; load_o is the extended load value,
// store_o the merged store word, misalign_o flags a bad alignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o,
    output logic        misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        load_o = '0;
        unique case (funct3_i)
            F3_B:    load_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    load_o = {{16{half_v[15]}}, half_v};
            F3_W:    load_o = word_i;
            F3_BU:   load_o = {24'h0, byte_v};
            F3_HU:   load_o = {16'h0, half_v};
            default: load_o = '0;
        endcase
    end

    // Sub-word stores replace only their lane of the word just read.
    always_comb begin
        store_o = word_i;
        unique case (funct3_i)
            F3_B: store_o[{off_i, 3'b000} +: 8] = sdata_i[7:0];
            F3_H: begin
                if (off_i[1]) begin
                    store_o[31:16] = sdata_i[15:0];
                end else begin
                    store_o[15:0] = sdata_i[15:0];
                end
            end
            default: store_o = sdata_i;
        endcase
    end

    // funct3[1:0] gives the access size for loads and stores alike.
    always_comb begin
        misalign_o = 1'b0;
        unique case (funct3_i[1:0])
            2'b01:   misalign_o = off_i[0];
            2'b10:   misalign_o = (off_i != 2'b00);
            default: misalign_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer onto a word-only memory port.
// Ports: req_* accept one access at a time (req_ready when idle),
// resp_* give a one-cycle completion pulse with data or error,
// mem_* drive the word memory; sub-word stores use read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [31:0] WinLim = win_limit(ADDR_W);

    lsu_state_e        state_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [31:0]       mem_wdata_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       rdata_q;

    logic              idle;
    logic [2:0]        al_f3;
    logic [1:0]        al_off;
    logic [31:0]       ld_val;
    logic [31:0]       st_word;
    logic              al_mis;
    logic              f3_bad;
    logic              req_err;

    assign idle = (state_q == S_IDLE);

    // While idle the aligner checks the incoming request; once busy
    // it works on the latched request.
    assign al_f3  = idle ? req_funct3 : f3_q;
    assign al_off = idle ? req_addr[1:0] : off_q;

    lsu_align u_align (
        .funct3_i   (al_f3),
        .off_i      (al_off),
        .word_i     (mem_rdata),
        .sdata_i    (wdata_q),
        .load_o     (ld_val),
        .store_o    (st_word),
        .misalign_o (al_mis)
    );

    always_comb begin
        if (req_we) begin
            f3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            f3_bad = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
    end

    assign req_err = f3_bad || al_mis || (req_addr >= WinLim);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (req_err) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (!req_we) begin
                                state_q    <= S_LOAD;
                                mem_read_q <= 1'b1;
                            end else if (req_funct3 == F3_W) begin
                                state_q     <= S_WRITE;
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end else begin
                                state_q    <= S_RMW_RD;
                                mem_read_q <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    state_q      <= S_RESP;
                    mem_read_q   <= 1'b0;
                    mem_addr_q   <= '0;
                    rdata_q      <= ld_val;
                    resp_valid_q <= 1'b1;
                end
                S_RMW_RD: begin
                    state_q     <= S_WRITE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    mem_wdata_q <= st_word;
                end
                S_WRITE: begin
                    state_q      <= S_RESP;
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    rdata_q      <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ready is held low during reset and rises as soon as it releases.
    assign req_ready  = idle && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model
// predicts responses and memory writes for every accepted request.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = '0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    int          acc_log[$];
    logic [31:0] mem[64];
    logic [7:0]  rmem[256];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic        abort_next = 1'b0;
    logic        cur_err = 1'b0;

    assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] = mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3.
    task automatic ref_exec(input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic err, output logic [31:0] rd,
                            output int lat, output logic wr,
                            output logic [31:0] ww);
        int sz;
        int ai;
        int base;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (we && f3[2]) sz = 0;
        ai = int'(a[7:0]);
        err = (sz == 0) || (a > 32'd255);
        if (!err && (ai % sz) != 0) err = 1'b1;
        rd = '0;
        wr = 1'b0;
        ww = '0;
        lat = 1;
        if (!err) begin
            if (!we) begin
                v = '0;
                for (int i = 0; i < sz; i++)
                    v = v | (32'(rmem[ai + i]) << (8 * i));
                if (!f3[2] && sz < 4 && v[8 * sz - 1])
                    v = v | ~((32'd1 << (8 * sz)) - 32'd1);
                rd = v;
                lat = 2;
            end else begin
                for (int i = 0; i < sz; i++)
                    rmem[ai + i] = d[8 * i +: 8];
                base = ai - (ai % 4);
                for (int j = 0; j < 4; j++)
                    ww[8 * j +: 8] = rmem[base + j];
                wr = 1'b1;
                lat = (sz == 4) ? 2 : 3;
            end
        end
    endtask

    // Stimulus side of the scoreboard: every accept pushes its expectation.
    always @(posedge clk) begin
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        logic        e_wr;
        logic [31:0] e_ww;
        if (!reset && req_valid && req_ready) begin
            acc_log.push_back(cyc + 1);
            if (abort_next) begin
                abort_next = 1'b0;
                cur_err = 1'b0;
            end else begin
                ref_exec(req_we, req_funct3, req_addr, req_wdata,
                         e_err, e_rd, e_lat, e_wr, e_ww);
                cur_err = e_err;
                exp_q.push_back('{err: e_err, rdata: e_rd,
                                  lat: e_lat, acc: cyc + 1});
                if (e_wr)
                    wr_q.push_back('{addr: {1'b0, req_addr[7:2], 2'b00},
                                     data: e_ww});
            end
        end
    end

    // Monitor: checks every response and memory write as it appears.
    exp_t mon_e;
    wr_t  mon_w;
    always @(negedge clk) begin
        if (!reset) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected: got resp err=%b rdata=%h want none",
                             resp_err, resp_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("resp_latency", 32'(cyc - mon_e.acc + 1),
                        32'(mon_e.lat));
                end
            end
            if (mem_write) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL write_unexpected: got addr=%h data=%h want none",
                             mem_addr, mem_wdata);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("mem_waddr", 32'(mem_addr), 32'(mon_w.addr));
                    chk("mem_wdata", mem_wdata, mon_w.data);
                end
            end
            if (mem_read || mem_write) begin
                chk("mem_on_err", 32'(cur_err), 32'd0);
                chk("mem_addr_bits", 32'({mem_addr[8], mem_addr[1:0]}), 32'd0);
                chk("rd_wr_excl", 32'(mem_read && mem_write), 32'd0);
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
        end else begin
            req_valid  = 1'b1;
            req_we     = we;
            req_funct3 = f3;
            req_addr   = a;
            req_wdata  = d;
            @(negedge clk);
            // Scramble the request lines to show they were latched.
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic        rwe;
        logic [2:0]  rf3;
        logic [31:0] ra;
        int          r;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            mem[i] = w;
            for (int j = 0; j < 4; j++) rmem[4 * i + j] = w[8 * j +: 8];
        end

        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        drive(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        drive(1'b0, F3_W, 32'h10, 32'h0);
        drive(1'b1, F3_W, 32'h20, 32'h11223344);
        drive(1'b1, F3_B, 32'h21, 32'h000000AA);
        drive(1'b0, F3_B, 32'h21, 32'h0);
        drive(1'b0, F3_BU, 32'h21, 32'h0);
        drive(1'b1, F3_W, 32'h30, 32'h0);
        drive(1'b1, F3_H, 32'h32, 32'h00008001);
        drive(1'b0, F3_H, 32'h32, 32'h0);
        drive(1'b0, F3_HU, 32'h32, 32'h0);
        drive(1'b0, F3_W, 32'h13, 32'h0);
        drive(1'b1, F3_H, 32'h05, 32'h1234);
        drive(1'b0, F3_B, 32'h100, 32'h0);
        drive(1'b0, 3'b011, 32'h0, 32'h0);
        drive(1'b1, F3_BU, 32'h8, 32'h0);
        drive(1'b0, F3_W, 32'h20, 32'h0);
        drain();

        // Reset while the SB read phase is in progress.
        abort_next = 1'b1;
        drive(1'b1, F3_B, 32'h45, 32'h0000005A);
        chk("rmw_read_active", 32'(mem_read), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_mem_read", 32'(mem_read), 32'd0);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        drive(1'b0, F3_W, 32'h44, 32'h0);
        drain();

        // Request held valid: one accept per response, every 3 edges.
        acc_log.delete();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        repeat (16) @(negedge clk);
        req_valid = 1'b0;
        chk("held_accepts", 32'(acc_log.size()), 32'd6);
        for (int i = 1; i < acc_log.size(); i++)
            chk("held_spacing", 32'(acc_log[i] - acc_log[i - 1]), 32'd3);
        drain();

        for (int k = 0; k < 250; k++) begin
            rwe = 1'($urandom);
            rf3 = 3'($urandom);
            if ($urandom_range(0, 7) != 0) begin
                r = $urandom_range(0, 4);
                case (r)
                    0: rf3 = F3_B;
                    1: rf3 = F3_H;
                    2: rf3 = F3_W;
                    3: rf3 = F3_BU;
                    default: rf3 = F3_HU;
                endcase
            end
            r = $urandom_range(0, 15);
            if (r == 0) ra = $urandom;
            else if (r < 4) ra = 32'($urandom_range(0, 255));
            else ra = 32'($urandom_range(0, 63));
            drive(rwe, rf3, ra, $urandom);
        end
        drain();
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
